// File: rtl/booth_pkg.sv
// booth_pkg: shared Booth digit encoding, default width and partial-product count helper for booth_multiplier
//   BOOTH_WIDTH  default operand width
//   NUM_PP       partial products at the default width
//   num_pp()     partial products for any even width
//   booth_decode triplet {x[2i+1], x[2i], x[2i-1]} -> Booth digit
package booth_pkg;

    typedef enum logic [2:0] {
        BOOTH_ZERO,
        BOOTH_P1,
        BOOTH_P2,
        BOOTH_M1,
        BOOTH_M2
    } booth_op_e;

    localparam int BOOTH_WIDTH = 8;

    function automatic int num_pp(input int width);
        return width / 2;
    endfunction

    localparam int NUM_PP = num_pp(BOOTH_WIDTH);

    function automatic booth_op_e booth_decode(input logic [2:0] triplet);
        booth_op_e op;
        case (triplet)
            3'b001, 3'b010: op = BOOTH_P1;
            3'b011:         op = BOOTH_P2;
            3'b100:         op = BOOTH_M2;
            3'b101, 3'b110: op = BOOTH_M1;
            default:        op = BOOTH_ZERO;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_multiplier_pp_gen.sv
// booth_pp_gen: one radix-4 Booth partial product (unshifted, WIDTH+2 bits)
//   triplet  in   Booth triplet {x[2i+1], x[2i], x[2i-1]}
//   w2mul    in   signed multiplicand
//   pp       out  selected multiple; negative digits give the one's complement
//   neg      out  +1 carry completing the two's-complement negation
//   sign     out  sign bit used to extend pp to full product width
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH
) (
    input  logic [2:0]       triplet,
    input  logic [WIDTH-1:0] w2mul,
    output logic [WIDTH+1:0] pp,
    output logic             neg,
    output logic             sign
);

    booth_op_e        op;
    logic [WIDTH+1:0] w1;
    logic [WIDTH+1:0] w2;

    always_comb begin
        op   = booth_decode(triplet);
        w1   = {{2{w2mul[WIDTH-1]}}, w2mul};
        w2   = {w2mul[WIDTH-1], w2mul, 1'b0};
        pp   = (op == BOOTH_P1) ? w1 :
               (op == BOOTH_P2) ? w2 :
               (op == BOOTH_M1) ? ~w1 :
               (op == BOOTH_M2) ? ~w2 : '0;
        neg  = (op == BOOTH_M1) || (op == BOOTH_M2);
        sign = pp[WIDTH+1];
    end

endmodule

// File: rtl/booth_multiplier.sv
// booth_multiplier: two-stage pipelined signed radix-4 Booth multiplier, product valid two edges after sampling
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset, clears all stages
//   w2mul      in   signed multiplicand
//   x2mul      in   signed multiplier (Booth-recoded)
//   mul2acc    out  registered signed 2*WIDTH-bit product
//   valid_in   in   (BOOTHMUL_VALID_EN only) operands valid, stage 1 loads only when set
//   valid_out  out  (BOOTHMUL_VALID_EN only) mul2acc holds a new product
module booth_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH
) (
`ifdef BOOTHMUL_VALID_EN
    input  logic               valid_in,
    output logic               valid_out,
`endif
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   w2mul,
    input  logic [WIDTH-1:0]   x2mul,
    output logic [2*WIDTH-1:0] mul2acc
);

    localparam int NPP = num_pp(WIDTH);
    localparam int PW  = 2 * WIDTH;

    logic [WIDTH:0]   x_ext;
    logic [WIDTH+1:0] pp [NPP];
    logic [NPP-1:0]   neg;
    logic [NPP-1:0]   sgn;

    logic [PW-1:0] pp_d [NPP];
    logic [PW-1:0] pp_q [NPP];
    logic [PW-1:0] carry_d, carry_q;
    logic [PW-1:0] sum;
    logic [PW-1:0] mul2acc_d, mul2acc_q;
    logic          ld1, ld2;

    // x[-1] = 0 is appended below the LSB so triplet i is x_ext[2i+2:2i]
    assign x_ext = {x2mul, 1'b0};

    for (genvar g = 0; g < NPP; g++) begin : g_pp
        booth_pp_gen #(.WIDTH(WIDTH)) u_pp (
            .triplet(x_ext[2*g+2 -: 3]),
            .w2mul  (w2mul),
            .pp     (pp[g]),
            .neg    (neg[g]),
            .sign   (sgn[g])
        );
    end

`ifdef BOOTHMUL_VALID_EN
    logic v1_q, v2_q;
    assign ld1       = valid_in;
    assign ld2       = v1_q;
    assign valid_out = v2_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= valid_in;
            v2_q <= v1_q;
        end
    end
`else
    assign ld1 = 1'b1;
    assign ld2 = 1'b1;
`endif

    // Stage 1: sign-extend and place each PP at weight 4^i; negation carries land at bit 2i
    always_comb begin
        carry_d = '0;
        for (int i = 0; i < NPP; i++) begin
            pp_d[i] = ld1 ? (PW'({{WIDTH{sgn[i]}}, pp[i]}) << (2 * i)) : pp_q[i];
            carry_d[2*i] = neg[i];
        end
        carry_d = ld1 ? carry_d : carry_q;
    end

    // Stage 2: plain modulo-2^PW sum of all PPs plus the carry vector
    always_comb begin
        sum = carry_q;
        for (int i = 0; i < NPP; i++)
            sum = sum + pp_q[i];
        mul2acc_d = ld2 ? sum : mul2acc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pp_q      <= '{default: '0};
            carry_q   <= '0;
            mul2acc_q <= '0;
        end else begin
            pp_q      <= pp_d;
            carry_q   <= carry_d;
            mul2acc_q <= mul2acc_d;
        end
    end

    assign mul2acc = mul2acc_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// tb_booth_multiplier: randomized and directed checks of booth_multiplier against an arithmetic product model
module tb_booth_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  w2mul = '0;
    logic [7:0]  x2mul = '0;
    logic [15:0] mul2acc;
    int          checks = 0;
    int          errors = 0;
`ifdef BOOTHMUL_VALID_EN
    logic valid_in = 1'b1;
    logic valid_out;
`endif

    booth_multiplier #(.WIDTH(8)) dut (
`ifdef BOOTHMUL_VALID_EN
        .valid_in (valid_in),
        .valid_out(valid_out),
`endif
        .clk      (clk),
        .rst      (rst),
        .w2mul    (w2mul),
        .x2mul    (x2mul),
        .mul2acc  (mul2acc)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_mul(input logic [7:0] w, input logic [7:0] x);
        return 16'(int'($signed(w)) * int'($signed(x)));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        x2mul = 8'(-5);
        w2mul = 8'd8;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (mul2acc !== 16'h0) begin
                errors++;
                $display("FAIL reset_hold edge %0d got %h want 0000", i, mul2acc);
            end
        end
    endtask

    task automatic test_latency();
        logic [15:0] exp;
        exp = 16'(-40);
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++;
        if (mul2acc !== 16'h0) begin
            errors++;
            $display("FAIL latency_edge1 got %h want 0000", mul2acc);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (mul2acc !== exp) begin
                errors++;
                $display("FAIL latency_edge%0d got %h want %h", i + 2, mul2acc, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp;
        exp = 16'(-40);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (mul2acc !== 16'h0) begin
            errors++;
            $display("FAIL async_clear got %h want 0000", mul2acc);
        end
        step();
        checks++;
        if (mul2acc !== 16'h0) begin
            errors++;
            $display("FAIL reset_held got %h want 0000", mul2acc);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++;
        if (mul2acc !== 16'h0) begin
            errors++;
            $display("FAIL post_reset_edge1 got %h want 0000", mul2acc);
        end
        step();
        checks++;
        if (mul2acc !== exp) begin
            errors++;
            $display("FAIL post_reset_edge2 got %h want %h", mul2acc, exp);
        end
    endtask

    task automatic test_corners();
        logic [7:0]  cw [7];
        logic [7:0]  cx [7];
        logic [15:0] q [$];
        logic [15:0] exp;
        cw = '{8'h80, 8'h80, 8'h7f, 8'h00, 8'hff, 8'h7f, 8'h55};
        cx = '{8'h80, 8'h7f, 8'h7f, 8'hff, 8'hff, 8'h80, 8'haa};
        for (int i = 0; i <= 7; i++) begin
            if (i < 7) begin
                w2mul = cw[i];
                x2mul = cx[i];
                q.push_back(ref_mul(cw[i], cx[i]));
            end
            step();
            if (i >= 1) begin
                exp = q.pop_front();
                checks++;
                if (mul2acc !== exp) begin
                    errors++;
                    $display("FAIL corner %0d w=%h x=%h got %h want %h", i - 1, cw[i-1], cx[i-1], mul2acc, exp);
                end
            end
        end
    endtask

    task automatic test_stream();
        logic [15:0] q [$];
        logic [15:0] exp;
        logic [7:0]  w, x;
        for (int i = 0; i <= 1000; i++) begin
            if (i < 1000) begin
                w = 8'($urandom);
                x = 8'($urandom);
                w2mul = w;
                x2mul = x;
                q.push_back(ref_mul(w, x));
            end
            step();
            if (i >= 1) begin
                exp = q.pop_front();
                checks++;
                if (mul2acc !== exp) begin
                    errors++;
                    $display("FAIL stream cycle %0d got %h want %h", i - 1, mul2acc, exp);
                end
            end
        end
    endtask

`ifdef BOOTHMUL_VALID_EN
    task automatic test_valid();
        logic [7:0]  vw [3];
        logic [7:0]  vx [3];
        logic        vin [3];
        logic        vexp [3];
        logic [15:0] pexp [3];
        vw   = '{8'd3, 8'd100, 8'hf9};
        vx   = '{8'd7, 8'h9c, 8'd11};
        vin  = '{1'b1, 1'b0, 1'b1};
        vexp = '{1'b1, 1'b0, 1'b1};
        pexp = '{ref_mul(vw[0], vx[0]), ref_mul(vw[0], vx[0]), ref_mul(vw[2], vx[2])};
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                w2mul    = vw[i];
                x2mul    = vx[i];
                valid_in = vin[i];
            end else begin
                valid_in = 1'b0;
            end
            step();
            if (i >= 1 && i <= 3) begin
                checks++;
                if (valid_out !== vexp[i-1]) begin
                    errors++;
                    $display("FAIL valid_out slot %0d got %b want %b", i - 1, valid_out, vexp[i-1]);
                end
                checks++;
                if (mul2acc !== pexp[i-1]) begin
                    errors++;
                    $display("FAIL valid_data slot %0d got %h want %h", i - 1, mul2acc, pexp[i-1]);
                end
            end
        end
        valid_in = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_reset_mid();
        test_corners();
        test_stream();
`ifdef BOOTHMUL_VALID_EN
        test_valid();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
